// File: rtl/phase_encoder4_2.sv
// ---------------------------------------------------------------------------
// phase_encoder4_2
//
// Monitor-side decoder for a full-step stepper. Takes the four coil lines
// (asynchronous to clk), synchronizes and optionally glitch-filters them,
// then recovers the 2-bit phase index, the direction of the last step and a
// signed position count. Illegal coil patterns and skipped phases raise a
// sticky fault that only err_clr can release.
//
// Optional feature macro: PHASE_ENCODER4_2_FILTER_EN
//   defined     -> a pattern is accepted after FILT identical samples
//   not defined -> every synchronized sample is accepted (FILT ignored)
//
// Parameters:
//   POS_W    width of the position counter
//   FILT     identical synchronized samples needed to accept a pattern (>=1)
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   b2/b1/a2/a1  coil lines, asynchronous
//   clr      synchronous clear of pos
//   err_clr  synchronous clear of err, only acts in the fault state
//   cnt      recovered phase index
//   valid    cnt reflects a tracked legal pattern
//   step     one-cycle pulse per accepted step
//   dir      direction of last step (1 = cnt incremented)
//   pos      signed position, two's complement, wraps
//   err      sticky fault flag
// ---------------------------------------------------------------------------
module phase_encoder4_2 #(
  parameter int POS_W = 16,
  parameter int FILT  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             b2,
  input  logic             b1,
  input  logic             a2,
  input  logic             a1,
  input  logic             clr,
  input  logic             err_clr,
  output logic [1:0]       cnt,
  output logic             valid,
  output logic             step,
  output logic             dir,
  output logic [POS_W-1:0] pos,
  output logic             err
);

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    FAULT
  } state_t;

  typedef enum logic [1:0] {
    CLS_PHASE,
    CLS_OFF,
    CLS_ILLEGAL
  } cls_t;

  if (FILT < 1) begin : g_filt_check
    $error("phase_encoder4_2: FILT must be at least 1");
  end

  logic [3:0] sync1;
  logic [3:0] sync2;
  logic       acc_valid;
  logic [3:0] acc_code;

  // Two-flop synchronizer on the coil bus {b2,b1,a2,a1}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 4'b0000;
      sync2 <= 4'b0000;
    end else begin
      sync1 <= {b2, b1, a2, a1};
      sync2 <= sync1;
    end
  end

`ifdef PHASE_ENCODER4_2_FILTER_EN
  localparam int             CW     = $clog2(FILT + 1);
  localparam logic [CW-1:0]  FILT_V = CW'(FILT);

  logic [3:0]    last_code;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] run_next;

  // Run length of the current synchronized code, saturating at FILT so a
  // pattern that stays put keeps being accepted every cycle.
  always_comb begin
    run_next = run_cnt;
    if (sync2 != last_code) begin
      run_next = CW'(1);
    end else if (run_cnt != FILT_V) begin
      run_next = run_cnt + CW'(1);
    end
  end

  // Acceptance register: a code is handed to the tracker only once its run
  // has reached FILT samples; shorter runs vanish without a trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_code <= 4'b0000;
      run_cnt   <= '0;
      acc_valid <= 1'b0;
      acc_code  <= 4'b0000;
    end else begin
      last_code <= sync2;
      run_cnt   <= run_next;
      acc_valid <= (run_next == FILT_V);
      acc_code  <= sync2;
    end
  end
`else
  // Unfiltered: every synchronized sample is accepted, one register later so
  // latency matches the filtered build running with FILT=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_valid <= 1'b0;
      acc_code  <= 4'b0000;
    end else begin
      acc_valid <= 1'b1;
      acc_code  <= sync2;
    end
  end
`endif

  cls_t       acc_cls;
  logic [1:0] acc_phase;

  // Coil pattern classifier; anything other than the four one-pair-of-coils
  // patterns or all-off is treated as a wiring or driver fault.
  always_comb begin
    acc_cls   = CLS_ILLEGAL;
    acc_phase = 2'd0;
    case (acc_code)
      4'b0110: begin acc_cls = CLS_PHASE; acc_phase = 2'd0; end
      4'b0011: begin acc_cls = CLS_PHASE; acc_phase = 2'd1; end
      4'b1001: begin acc_cls = CLS_PHASE; acc_phase = 2'd2; end
      4'b1100: begin acc_cls = CLS_PHASE; acc_phase = 2'd3; end
      4'b0000: acc_cls = CLS_OFF;
      default: acc_cls = CLS_ILLEGAL;
    endcase
  end

  state_t           state;
  state_t           next_state;
  logic [1:0]       next_cnt;
  logic             next_valid;
  logic             next_step;
  logic             next_dir;
  logic [POS_W-1:0] next_pos;
  logic             next_err;
  logic [1:0]       delta;

  // Tracker next-state logic. delta is the modulo-4 phase distance; a
  // distance of 2 means the direction is ambiguous (a phase was skipped).
  // err_clr is only looked at in FAULT, so a fault raised in the same cycle
  // always wins over a clear.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_valid = valid;
    next_step  = 1'b0;
    next_dir   = dir;
    next_pos   = pos;
    next_err   = err;
    delta      = acc_phase - cnt;

    case (state)
      SEARCH: begin
        if (acc_valid) begin
          case (acc_cls)
            CLS_PHASE: begin
              next_cnt   = acc_phase;
              next_valid = 1'b1;
              next_state = TRACK;
            end
            CLS_ILLEGAL: begin
              next_err   = 1'b1;
              next_valid = 1'b0;
              next_state = FAULT;
            end
            default: ;
          endcase
        end
      end

      TRACK: begin
        if (acc_valid) begin
          case (acc_cls)
            CLS_PHASE: begin
              next_cnt = acc_phase;
              case (delta)
                2'd1: begin
                  next_step = 1'b1;
                  next_dir  = 1'b1;
                  next_pos  = pos + POS_W'(1);
                end
                2'd3: begin
                  next_step = 1'b1;
                  next_dir  = 1'b0;
                  next_pos  = pos - POS_W'(1);
                end
                2'd2: begin
                  next_err   = 1'b1;
                  next_valid = 1'b0;
                  next_state = FAULT;
                end
                default: ;
              endcase
            end
            CLS_OFF: begin
              next_valid = 1'b0;
              next_state = SEARCH;
            end
            default: begin
              next_err   = 1'b1;
              next_valid = 1'b0;
              next_state = FAULT;
            end
          endcase
        end
      end

      FAULT: begin
        next_valid = 1'b0;
        if (err_clr) begin
          next_err   = 1'b0;
          next_state = SEARCH;
        end
      end

      default: begin
        next_valid = 1'b0;
        next_state = SEARCH;
      end
    endcase

    if (clr) begin
      next_pos = '0;
    end
  end

  // Output and state registers; all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEARCH;
      cnt   <= 2'd0;
      valid <= 1'b0;
      step  <= 1'b0;
      dir   <= 1'b0;
      pos   <= '0;
      err   <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      valid <= next_valid;
      step  <= next_step;
      dir   <= next_dir;
      pos   <= next_pos;
      err   <= next_err;
    end
  end

endmodule

// File: doc/phase_encoder4_2.md
# phase_encoder4_2

Recovers the 2-bit phase index, step direction and a signed position count from the four full-step stepper coil lines A1, A2, B1, B2. This is the inverse of the 2-to-4 coil decoder. Sits on the monitor side of the motor path: the coil lines come from a driver or a second board, arrive asynchronous to CLK, and are filtered before use. Illegal coil patterns and skipped phases raise a sticky fault.

## Interface
- POS_W, 16: width of position counter POS.
- FILT, 3: consecutive identical synchronized samples required to accept a pattern (≥1).

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- B2  input  1  coil B2 (blue), asynchronous.
- B1  input  1  coil B1 (pink), asynchronous.
- A2  input  1  coil A2 (yellow), asynchronous.
- A1  input  1  coil A1 (orange), asynchronous.
- CLR  input  1  synchronous clear of POS.
- ERR_CLR  input  1  synchronous clear of ERR; leaves FAULT.
- CNT  output  2  recovered phase index.
- VALID  output  1  CNT reflects a tracked legal pattern.
- STEP  output  1  one-cycle pulse per accepted step.
- DIR  output  1  direction of last step: 1 = CNT increment, 0 = decrement.
- POS  output  POS_W  signed position, two's complement.
- ERR  output  1  sticky fault flag.

## Operation
- Synchronizer: 2-FF on each coil line; reset value 0.
- Classify synchronized code {B2,B1,A2,A1}:
  - 0110 → phase 0; 0011 → 1; 1001 → 2; 1100 → 3.
  - 0000 → OFF.
  - Any other code → ILLEGAL.
- Filter: a classified code is accepted only after it is identical on FILT consecutive samples. Shorter runs are discarded silently.
- FSM states SEARCH, TRACK, FAULT; reset → SEARCH.
  - SEARCH:
    - Accepted legal phase p → CNT=p, VALID=1, no STEP, POS unchanged, go TRACK.
    - OFF → stay.
    - ILLEGAL → ERR=1, go FAULT.
  - TRACK, accepted phase p, d=(p−CNT) mod 4:
    - d=1 → STEP, DIR=1, POS+1.
    - d=3 → STEP, DIR=0, POS−1.
    - d=0 → nothing.
    - d=2 (skipped phase) → ERR=1, VALID=0, go FAULT; POS unchanged.
    - CNT=p in every case.
  - TRACK, accepted OFF → VALID=0, go SEARCH, no error (coils de-energized).
  - TRACK, accepted ILLEGAL → ERR=1, VALID=0, go FAULT.
  - FAULT: VALID=0, STEP=0, all patterns ignored. ERR_CLR=1 → ERR=0, go SEARCH.
- POS: wraps modulo 2^POS_W (0x7FFF+1 → 0x8000; 0x0000−1 → 0xFFFF). Held across SEARCH and FAULT.
- CLR in any state → POS=0 next edge. CLR with a simultaneous step: POS=0, STEP and DIR still update.
- ERR_CLR coinciding with a new fault: the fault wins; ERR stays 1, state FAULT.
- ERR_CLR outside FAULT: no effect.

## Timing
- Reset values: CNT=0, VALID=0, STEP=0, DIR=0, POS=0, ERR=0, state SEARCH, filter cleared.
- Reset asserted mid-operation returns every output to its reset value immediately. Tracking restarts in SEARCH after RST_N rises.
- Latency: a coil change present before edge 0 updates CNT, VALID, STEP, DIR, POS and ERR on edge 2+FILT (FILT=3 → edge 5).
- STEP high for exactly one cycle per accepted step.
- Maximum step rate: one step per FILT cycles.
- All outputs registered; none combinational from inputs.

## Configuration
- PHASE_ENCODER4_2_FILTER_EN defined: glitch filter present as described; FILT is honoured.
- Not defined: filter removed and FILT ignored. Every synchronized sample is accepted, behaving as FILT=1, with output latency of edge 3. Any single-cycle transient is acted upon, so an illegal glitch faults.

## Test plan
- Reset, then apply 0110 → after latency CNT=0, VALID=1, STEP never pulses, POS=0.
- From phase 0, drive 0011, 1001, 1100, 0110, each held 8 cycles → four STEP pulses, DIR=1, POS=4, CNT=0.
- Same sequence reversed from phase 0 → POS=0xFFFC, DIR=0. Then CLR alongside one further step → POS=0, STEP=1.
- From phase 0, drive 1001 (skip) → ERR=1, VALID=0, POS unchanged. Pulse ERR_CLR, apply 1100 → VALID=1, CNT=3, no STEP.
- With FILTER_EN and FILT=3, a 2-cycle 1111 glitch inside a 0011 hold → no ERR, no STEP. A 3-cycle 1111 → ERR=1.
- Track to POS=0x7FFF, one forward step → POS=0x8000. Drive 0000 → VALID=0, ERR=0, state SEARCH.
